// File: rtl/led_pattern_gen_pkg.sv
// rtl/led_pattern_gen_pkg.sv - shared encodings for the LED pattern generator
package led_pattern_gen_pkg;

    localparam int MODE_W = 3;
    localparam int DUTY_W = 8;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;
    localparam int PWM_W  = 8;

    // Channel operating modes; encodings 5..7 are reserved and behave as OFF.
    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_PWM   = 3'd3,
        MODE_BURST = 3'd4
    } mode_e;

    // Per-channel burst sequencer states.
    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_ON   = 2'd1,
        BS_OFF  = 2'd2
    } burst_state_e;

endpackage

// File: rtl/led_pattern_gen_channel.sv
// rtl/led_pattern_gen_channel.sv - one LED channel: config, phase counter, burst FSM, output flops
module led_pattern_gen_channel
    import led_pattern_gen_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [PWM_W-1:0]  pwm_cnt,
    input  logic              we,
    input  logic [MODE_W-1:0] mode_in,
    input  logic [PER_W-1:0]  half_in,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic [CNT_W-1:0]  count_in,
    output logic              led,
    output logic              busy,
    output logic              done
);

    localparam logic [PER_W-1:0] PHASE_ONE = PER_W'(1);
    localparam logic [CNT_W-1:0] REM_ONE   = CNT_W'(1);

    logic [MODE_W-1:0] mode_q,  mode_d;
    logic [PER_W-1:0]  half_q,  half_d;
    logic [DUTY_W-1:0] duty_q,  duty_d;
    logic [CNT_W-1:0]  rem_q,   rem_d;
    logic [PER_W-1:0]  phase_q, phase_d;
    burst_state_e      state_q, state_d;
    logic              led_q,   led_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [PER_W-1:0]  half_eff;
    logic              phase_last;

    // A programmed half-period of zero behaves as one tick.
    always_comb begin
        half_eff   = (half_q == '0) ? PHASE_ONE : half_q;
        phase_last = (phase_q == (half_eff - PHASE_ONE));
    end

    // Next-state logic: a config write always wins over the running pattern.
    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        duty_d  = duty_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        state_d = state_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (we) begin
            mode_d  = mode_in;
            half_d  = half_in;
            duty_d  = duty_in;
            rem_d   = count_in;
            phase_d = '0;
            state_d = BS_IDLE;
            busy_d  = 1'b0;
            case (mode_in)
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = 1'b1;
                MODE_PWM:   led_d = (pwm_cnt < duty_in);
                MODE_BURST: begin
                    if (count_in != '0) begin
                        state_d = BS_ON;
                        busy_d  = 1'b1;
                        led_d   = 1'b1;
                    end else begin
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
                default:    led_d = 1'b0;
            endcase
        end else begin
            case (mode_q)
                MODE_ON: led_d = 1'b1;
                MODE_BLINK: begin
                    if (tick) begin
                        if (phase_last) begin
                            phase_d = '0;
                            led_d   = ~led_q;
                        end else begin
                            phase_d = phase_q + PHASE_ONE;
                        end
                    end
                end
                MODE_PWM: led_d = (pwm_cnt < duty_q);
                MODE_BURST: begin
                    if (tick && (state_q != BS_IDLE)) begin
                        if (phase_last) begin
                            phase_d = '0;
                            case (state_q)
                                BS_ON: begin
                                    rem_d = rem_q - REM_ONE;
                                    led_d = 1'b0;
                                    // Last pulse: finish on its falling edge, skip the trailing off half.
                                    if (rem_q == REM_ONE) begin
                                        state_d = BS_IDLE;
                                        busy_d  = 1'b0;
                                        done_d  = 1'b1;
                                    end else begin
                                        state_d = BS_OFF;
                                    end
                                end
                                BS_OFF: begin
                                    state_d = BS_ON;
                                    led_d   = 1'b1;
                                end
                                default: state_d = BS_IDLE;
                            endcase
                        end else begin
                            phase_d = phase_q + PHASE_ONE;
                        end
                    end
                end
                default: begin
                    led_d  = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            half_q  <= '0;
            duty_q  <= '0;
            rem_q   <= '0;
            phase_q <= '0;
            state_q <= BS_IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            duty_q  <= duty_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator top level
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 1000,
    parameter int PER_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [PER_W-1:0]  cfg_half,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    // CLK_HZ must be an integer multiple (>= 2) of TICK_HZ.
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [CH_W:0]      NUM_CH_W   = (CH_W + 1)'(NUM_CH);

    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               tick;
    logic               ch_ok;
    logic [NUM_CH-1:0]  ch_we;

    // Shared timebase: free-running prescaler and PWM ramp, untouched by config writes.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        ch_ok     = ({1'b0, cfg_ch} < NUM_CH_W);
    end

    // Timebase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we & ch_ok & (cfg_ch == CH_W'(i));

        led_pattern_gen_channel #(
            .PER_W(PER_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt_q),
            .we       (ch_we[i]),
            .mode_in  (cfg_mode),
            .half_in  (cfg_half),
            .duty_in  (cfg_duty),
            .count_in (cfg_count),
            .led      (led[i]),
            .busy     (busy[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized self-checking bench with a tick-count reference model
module tb_led_pattern_gen;

    localparam int NUM_CH  = 3;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int PER_W   = 16;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [2:0]        cfg_mode;
    logic [PER_W-1:0]  cfg_half;
    logic [7:0]        cfg_duty;
    logic [7:0]        cfg_count;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    led_pattern_gen #(
        .NUM_CH (NUM_CH),
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .PER_W  (PER_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .cfg_duty (cfg_duty),
        .cfg_count(cfg_count),
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each channel remembers its config and how many ticks
    // have elapsed since it was written; outputs follow from plain arithmetic.
    int k;
    int m_mode  [NUM_CH];
    int m_half  [NUM_CH];
    int m_duty  [NUM_CH];
    int m_count [NUM_CH];
    int m_ticks [NUM_CH];
    bit m_wr    [NUM_CH];
    bit m_tk    [NUM_CH];
    logic [NUM_CH-1:0] exp_led, exp_busy, exp_done;

    task automatic model_edge();
        bit tick;
        int seg;
        int last;
        if (rst) begin
            k = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0; m_half[c] = 1; m_duty[c] = 0; m_count[c] = 0; m_ticks[c] = 0;
            end
            exp_led = '0; exp_busy = '0; exp_done = '0;
            return;
        end
        k++;
        tick = ((k % DIV) == 0);
        for (int c = 0; c < NUM_CH; c++) begin
            m_wr[c] = 1'b0;
            m_tk[c] = 1'b0;
            if (cfg_we && (int'(cfg_ch) == c)) begin
                m_mode[c]  = int'(cfg_mode);
                m_half[c]  = (cfg_half == 0) ? 1 : int'(cfg_half);
                m_duty[c]  = int'(cfg_duty);
                m_count[c] = int'(cfg_count);
                m_ticks[c] = 0;
                m_wr[c]    = 1'b1;
            end else if (tick) begin
                m_ticks[c]++;
                m_tk[c] = 1'b1;
            end
            exp_led[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
            case (m_mode[c])
                1: exp_led[c] = 1'b1;
                2: exp_led[c] = (((m_ticks[c] / m_half[c]) % 2) == 0);
                3: exp_led[c] = (((k - 1) % 256) < m_duty[c]);
                4: begin
                    if (m_count[c] == 0) begin
                        exp_done[c] = m_wr[c];
                    end else begin
                        seg  = m_ticks[c] / m_half[c];
                        last = 2 * m_count[c] - 1;
                        if (seg < last) begin
                            exp_led[c]  = ((seg % 2) == 0);
                            exp_busy[c] = 1'b1;
                        end else begin
                            exp_done[c] = m_tk[c] && (seg == last) && ((m_ticks[c] % m_half[c]) == 0);
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wr(input int ch, input int mode, input int half, input int duty, input int cnt);
        cfg_we    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_mode  = 3'(mode);
        cfg_half  = PER_W'(half);
        cfg_duty  = 8'(duty);
        cfg_count = 8'(cnt);
    endtask

    task automatic align_tick();
        for (int i = 0; (i < DIV) && (((k + 1) % DIV) != 0); i++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_we = 1'($urandom); cfg_ch = 3'($urandom); cfg_mode = 3'($urandom);
            cfg_half = PER_W'($urandom_range(0, 3)); cfg_duty = 8'($urandom); cfg_count = 8'($urandom);
            cycle();
            checks++;
            if ({led, busy, done} !== 9'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got led=%b busy=%b done=%b want all zero", i, led, busy, done);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({led, busy, done} !== 9'b0) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got led=%b busy=%b done=%b want all zero", i, led, busy, done);
            end
        end
    endtask

    task automatic test_blink();
        int   last_t;
        int   kw;
        int   first;
        logic prev;
        int   halves [2] = '{3, 0};
        int   ivals  [2] = '{30, 10};
        for (int t = 0; t < 2; t++) begin
            wr(0, 2, halves[t], 0, 0);
            cycle();
            checks++;
            if (led[0] !== 1'b1) begin
                failures++;
                $display("FAIL blink_start half=%0d got led0=%b want 1", halves[t], led[0]);
            end
            prev   = led[0];
            last_t = -1;
            for (int i = 0; i < 120; i++) begin
                cycle();
                checks++;
                if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                    failures++;
                    $display("FAIL blink k=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b", k, led, busy, done, exp_led, exp_busy, exp_done);
                end
                if (led[0] !== prev) begin
                    if (last_t >= 0) begin
                        checks++;
                        if (k - last_t != ivals[t]) begin
                            failures++;
                            $display("FAIL blink_interval half=%0d got %0d want %0d", halves[t], k - last_t, ivals[t]);
                        end
                    end
                    last_t = k;
                    prev   = led[0];
                end
            end
        end
        // Write landing on a tick edge: phase restarts, first toggle 2 ticks later.
        align_tick();
        wr(0, 2, 2, 0, 0);
        cycle();
        kw    = k;
        first = -1;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if ((first < 0) && (led[0] !== 1'b1)) first = k - kw;
        end
        checks++;
        if (first != 20) begin
            failures++;
            $display("FAIL blink_tick_write first toggle got %0d want 20", first);
        end
    endtask

    task automatic test_pwm();
        int duties [4];
        int hi;
        duties = '{64, 0, 255, int'($urandom_range(1, 254))};
        for (int t = 0; t < 4; t++) begin
            wr(1, 3, 0, duties[t], 0);
            cycle();
            hi = int'(led[1]);
            for (int i = 0; i < 255; i++) begin
                cycle();
                checks++;
                if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                    failures++;
                    $display("FAIL pwm k=%0d got led=%b want led=%b", k, led, exp_led);
                end
                hi += int'(led[1]);
            end
            checks++;
            if (hi != duties[t]) begin
                failures++;
                $display("FAIL pwm_window duty=%0d got %0d high cycles want %0d", duties[t], hi, duties[t]);
            end
        end
    endtask

    task automatic test_burst();
        int   hi;
        int   nb;
        int   nd;
        logic prev;
        align_tick();
        wr(2, 4, 1, 0, 2);
        cycle();
        hi = int'(led[2]); nb = int'(busy[2]); nd = 0; prev = led[2];
        for (int i = 0; i < 40; i++) begin
            cycle();
            checks++;
            if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL burst k=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b", k, led, busy, done, exp_led, exp_busy, exp_done);
            end
            hi += int'(led[2]);
            nb += int'(busy[2]);
            if (done[2] === 1'b1) begin
                nd++;
                checks++;
                if (!(prev === 1'b1 && led[2] === 1'b0)) begin
                    failures++;
                    $display("FAIL burst_done_on_fall got prev=%b led=%b want 1->0", prev, led[2]);
                end
            end
            prev = led[2];
        end
        checks++;
        if (hi != 20 || nb != 30 || nd != 1) begin
            failures++;
            $display("FAIL burst_counts got high=%0d busy=%0d done=%0d want 20 30 1", hi, nb, nd);
        end
        wr(2, 4, 1, 0, 0);
        cycle();
        checks++;
        if ({led[2], busy[2], done[2]} !== 3'b001) begin
            failures++;
            $display("FAIL burst_zero got led=%b busy=%b done=%b want 0 0 1", led[2], busy[2], done[2]);
        end
        cycle();
        checks++;
        if (done[2] !== 1'b0) begin
            failures++;
            $display("FAIL burst_zero_pulse got done=%b want 0", done[2]);
        end
    endtask

    task automatic test_abort();
        int nd;
        wr(2, 4, 2, 0, 3);
        cycle();
        for (int i = 0; i < 15; i++) cycle();
        wr(2, 1, 0, 0, 0);
        cycle();
        nd = 0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            checks++;
            if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL abort k=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b", k, led, busy, done, exp_led, exp_busy, exp_done);
            end
            nd += int'(done[2]);
        end
        checks++;
        if (nd != 0 || led[2] !== 1'b1) begin
            failures++;
            $display("FAIL abort_result got done_pulses=%0d led2=%b want 0 1", nd, led[2]);
        end
        wr(0, 1, 0, 0, 0); cycle();
        wr(1, 3, 0, 100, 0); cycle();
        wr(2, 2, 1, 0, 0); cycle();
        wr(3, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 30; i++) begin
            cycle();
            checks++;
            if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL bad_ch k=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b", k, led, busy, done, exp_led, exp_busy, exp_done);
            end
        end
        checks++;
        if (led[0] !== 1'b1) begin
            failures++;
            $display("FAIL bad_ch_ignored got led0=%b want 1", led[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int nd;
        wr(2, 4, 1, 0, 4);
        cycle();
        for (int i = 0; i < 15; i++) cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if ({led, busy, done} !== 9'b0) begin
            failures++;
            $display("FAIL rst_mid_burst got led=%b busy=%b done=%b want all zero", led, busy, done);
        end
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            checks++;
            if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL rst_after k=%0d got led=%b busy=%b done=%b want all zero", k, led, busy, done);
            end
            nd += int'(done[2]);
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL rst_no_done got %0d pulses want 0", nd);
        end
    endtask

    task automatic test_reserved();
        wr(0, 1, 0, 0, 0);   cycle();
        wr(1, 3, 0, 128, 0); cycle();
        wr(2, 2, 2, 0, 0);   cycle();
        for (int i = 0; i < 5; i++) cycle();
        wr(0, 6, 1, 1, 1);
        cycle();
        checks++;
        if (led[0] !== 1'b0) begin
            failures++;
            $display("FAIL reserved got led0=%b want 0", led[0]);
        end
        for (int i = 0; i < 40; i++) begin
            cycle();
            checks++;
            if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL reserved_others k=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b", k, led, busy, done, exp_led, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
            end
            cycle();
            checks++;
            if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL random k=%0d got led=%b busy=%b done=%b want led=%b busy=%b done=%b", k, led, busy, done, exp_led, exp_busy, exp_done);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_half = '0; cfg_duty = '0; cfg_count = '0; k = 0;
        test_reset();
        test_blink();
        test_pwm();
        test_burst();
        test_abort();
        test_reset_mid_burst();
        test_reserved();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
